// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Responder for ALU load/store requests. Issues a single
//               req/gnt/rvalid data-memory transaction per request, places
//               store data on the correct byte lanes, extracts and extends
//               load data, and returns loads as one register-writeback beat.
//               Illegal requests (misaligned, bad funct3, read+write) only
//               raise a one-cycle error pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int cDataWidth = 32,   // only 32 is supported (4 byte lanes)
   parameter int cRegAddrW  = 5
) (
   input  logic                  iClk,
   input  logic                  iRst,         // async, active-low
   // request side (ALU)
   input  logic                  iMemRead,
   input  logic                  iMemWrite,
   input  logic [cDataWidth-1:0] iMemAddr,
   input  logic [cDataWidth-1:0] iMemData,
   input  logic [2:0]            iMemOpType,
   input  logic [cRegAddrW-1:0]  iMemRdAddr,
   output logic                  oBusy,
   // data-memory bus
   output logic                  oDmemReq,
   output logic                  oDmemWe,
   output logic [cDataWidth-1:0] oDmemAddr,
   output logic [cDataWidth-1:0] oDmemWdata,
   output logic [3:0]            oDmemBe,
   input  logic                  iDmemGnt,
   input  logic                  iDmemRvalid,
   input  logic [cDataWidth-1:0] iDmemRdata,
   // register writeback
   output logic                  oRegDv,
   output logic [cRegAddrW-1:0]  oRegAddr,
   output logic [cDataWidth-1:0] oRegData,
   output logic                  oErr
);

   // funct3 encodings of the supported access types
   localparam logic [2:0] c_F3_B  = 3'b000;
   localparam logic [2:0] c_F3_H  = 3'b001;
   localparam logic [2:0] c_F3_W  = 3'b010;
   localparam logic [2:0] c_F3_BU = 3'b100;
   localparam logic [2:0] c_F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t                 r_state;
   logic                   r_is_load;   // captured request is a load
   logic [2:0]             r_op;        // captured funct3
   logic [1:0]             r_off;       // captured byte offset within the word
   logic [cRegAddrW-1:0]   r_rd;        // captured destination register

   logic                   w_req;
   logic                   w_op_ok;
   logic                   w_align_ok;
   logic                   w_legal;
   logic [3:0]             w_be;
   logic [cDataWidth-1:0]  w_wdata;
   logic [7:0]             w_byte;
   logic [15:0]            w_half;
   logic [cDataWidth-1:0]  w_load_result;

   // The bus is busy whenever a request is held in REQ or WAIT
   assign oBusy = (r_state != ST_IDLE);

   // Decode the incoming request: legality, byte enables and lane-replicated data
   always_comb begin
      w_req      = iMemRead | iMemWrite;
      w_op_ok    = 1'b0;
      w_align_ok = 1'b0;
      w_be       = 4'b0000;
      w_wdata    = iMemData;
      case (iMemOpType)
         c_F3_B: begin
            w_op_ok    = 1'b1;
            w_align_ok = 1'b1;
            w_be       = 4'b0001 << iMemAddr[1:0];
            w_wdata    = {4{iMemData[7:0]}};
         end
         c_F3_H: begin
            w_op_ok    = 1'b1;
            w_align_ok = ~iMemAddr[0];
            w_be       = iMemAddr[1] ? 4'b1100 : 4'b0011;
            w_wdata    = {2{iMemData[15:0]}};
         end
         c_F3_W: begin
            w_op_ok    = 1'b1;
            w_align_ok = (iMemAddr[1:0] == 2'b00);
            w_be       = 4'b1111;
            w_wdata    = iMemData;
         end
         // unsigned variants exist only for loads
         c_F3_BU: begin
            w_op_ok    = iMemRead;
            w_align_ok = 1'b1;
         end
         c_F3_HU: begin
            w_op_ok    = iMemRead;
            w_align_ok = ~iMemAddr[0];
         end
         default: begin
            w_op_ok    = 1'b0;
            w_align_ok = 1'b0;
         end
      endcase
      // loads always fetch the whole word and select the lane on return
      if (iMemRead) begin
         w_be = 4'b1111;
      end
      w_legal = w_op_ok & w_align_ok & ~(iMemRead & iMemWrite);
   end

   // Select the addressed lane from the returned word and extend it
   always_comb begin
      case (r_off)
         2'd0:    w_byte = iDmemRdata[7:0];
         2'd1:    w_byte = iDmemRdata[15:8];
         2'd2:    w_byte = iDmemRdata[23:16];
         default: w_byte = iDmemRdata[31:24];
      endcase
      w_half = r_off[1] ? iDmemRdata[31:16] : iDmemRdata[15:0];
      case (r_op)
         c_F3_B:  w_load_result = {{24{w_byte[7]}}, w_byte};
         c_F3_H:  w_load_result = {{16{w_half[15]}}, w_half};
         c_F3_BU: w_load_result = {24'd0, w_byte};
         c_F3_HU: w_load_result = {16'd0, w_half};
         default: w_load_result = iDmemRdata;
      endcase
   end

   // Transaction FSM with registered bus, writeback and error outputs
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         r_state    <= ST_IDLE;
         r_is_load  <= 1'b0;
         r_op       <= 3'b000;
         r_off      <= 2'b00;
         r_rd       <= '0;
         oDmemReq   <= 1'b0;
         oDmemWe    <= 1'b0;
         oDmemAddr  <= '0;
         oDmemWdata <= '0;
         oDmemBe    <= 4'b0000;
         oRegDv     <= 1'b0;
         oRegAddr   <= '0;
         oRegData   <= '0;
         oErr       <= 1'b0;
      end else begin
         // pulses default low every cycle
         oRegDv <= 1'b0;
         oErr   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  if (w_legal) begin
                     r_state    <= ST_REQ;
                     r_is_load  <= iMemRead;
                     r_op       <= iMemOpType;
                     r_off      <= iMemAddr[1:0];
                     r_rd       <= iMemRdAddr;
                     oDmemReq   <= 1'b1;
                     oDmemWe    <= iMemWrite;
                     oDmemAddr  <= {iMemAddr[cDataWidth-1:2], 2'b00};
                     oDmemWdata <= w_wdata;
                     oDmemBe    <= w_be;
                  end else begin
                     oErr <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               // bus fields stay frozen until the grant arrives
               if (iDmemGnt) begin
                  oDmemReq   <= 1'b0;
                  oDmemWe    <= 1'b0;
                  oDmemWdata <= '0;
                  oDmemBe    <= 4'b0000;
                  r_state    <= r_is_load ? ST_WAIT : ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (iDmemRvalid) begin
                  oRegData <= w_load_result;
                  oRegAddr <= r_rd;
                  oRegDv   <= (r_rd != '0);
                  r_state  <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
